// File: rtl/alu_sequencer_if.sv
// Instruction handshake bundle between an instruction source and alu_sequencer.
interface alu_sequencer_if #(parameter int RW = 2);
  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    instr_op;
  logic [RW-1:0] instr_rd;
  logic [RW-1:0] instr_rs;
  logic          instr_imm_en;
  logic [7:0]    instr_imm;

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs, instr_imm_en, instr_imm,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs, instr_imm_en, instr_imm,
    output instr_ready
  );
endinterface

// File: rtl/alu_sequencer.sv
// Execute-stage front end for an external combinational 8-bit ALU: operand fetch,
// settle, capture and write-back, one instruction in flight.
//   state   | meaning
//   S_IDLE  | ready; latch instruction on valid
//   S_LOAD  | register ALU select/operands from the register file
//   S_EXEC  | ALU settles; capture result and flags at end of cycle
//   S_WRITE | done pulse; write back capture regs at end of cycle
module alu_sequencer #(
  parameter int          NUM_REGS  = 4,
  parameter logic [7:0]  RESET_VAL = 8'h00,
  localparam int         RW        = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  alu_sequencer_if.slave      instr,
  output logic [3:0]          alu_fsel,
  output logic [7:0]          alu_opA,
  output logic [7:0]          alu_opB,
  input  logic [7:0]          alu_result,
  input  logic [3:0]          alu_sreg,
  output logic [3:0]          status,
  output logic                done,
  input  logic [RW-1:0]       dbg_addr,
  output logic [7:0]          dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_WRITE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [RW-1:0] rs_q, rs_d;
  logic          imm_en_q, imm_en_d;
  logic [7:0]    imm_q, imm_d;
  logic [3:0]    fsel_q, fsel_d;
  logic [7:0]    opa_q, opa_d;
  logic [7:0]    opb_q, opb_d;
  logic [7:0]    result_q, result_d;
  logic [3:0]    sreg_q, sreg_d;
  logic [3:0]    status_q, status_d;
  logic [7:0]    regs_q [NUM_REGS];
  logic [7:0]    regs_d [NUM_REGS];
  logic          wr_reg;
  logic          wr_status;

  // CMP only updates flags; every unlisted code is a NOP that still retires.
  always_comb begin
    wr_reg = 1'b0;
    case (op_q)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7: wr_reg = 1'b1;
      default:                            wr_reg = 1'b0;
    endcase
    wr_status = wr_reg || (op_q == 4'd5);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rs_d     = rs_q;
    imm_en_d = imm_en_q;
    imm_d    = imm_q;
    fsel_d   = fsel_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    sreg_d   = sreg_q;
    status_d = status_q;
    regs_d   = regs_q;
    case (state_q)
      S_IDLE: begin
        if (instr.instr_valid) begin
          op_d     = instr.instr_op;
          rd_d     = instr.instr_rd;
          rs_d     = instr.instr_rs;
          imm_en_d = instr.instr_imm_en;
          imm_d    = instr.instr_imm;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        fsel_d  = op_q;
        opa_d   = regs_q[rd_q];
        opb_d   = imm_en_q ? imm_q : regs_q[rs_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        result_d = alu_result;
        sreg_d   = alu_sreg;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        if (wr_reg)    regs_d[rd_q] = result_q;
        if (wr_status) status_d     = sreg_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      imm_en_q <= 1'b0;
      imm_q    <= '0;
      fsel_q   <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      sreg_q   <= '0;
      status_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs_q     <= rs_d;
      imm_en_q <= imm_en_d;
      imm_q    <= imm_d;
      fsel_q   <= fsel_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      sreg_q   <= sreg_d;
      status_q <= status_d;
      regs_q   <= regs_d;
    end
  end

  assign instr.instr_ready = (state_q == S_IDLE);
  assign done              = (state_q == S_WRITE);
  assign alu_fsel          = fsel_q;
  assign alu_opA           = opa_q;
  assign alu_opB           = opb_q;
  assign status            = status_q;
  assign dbg_data          = regs_q[dbg_addr];

endmodule
